// File: rtl/port_in_sync.sv
// Input-port front end: synchronise, debounce and flag changes on four external buses.
// Optional PORT_IRQ_EN adds a registered interrupt request gated by irq_mask.
module port_in_sync #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pin1,
    input  logic [WIDTH-1:0] pin2,
    input  logic [WIDTH-1:0] pin3,
    input  logic [WIDTH-1:0] pin4,
    input  logic [1:0]       s_port,
    input  logic             rd_ack,
    input  logic [3:0]       irq_mask,
    output logic [WIDTH-1:0] i1,
    output logic [WIDTH-1:0] i2,
    output logic [WIDTH-1:0] i3,
    output logic [WIDTH-1:0] i4,
    output logic [3:0]       chg,
    output logic             irq
);

    localparam int CW = $clog2(DEB_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    logic [WIDTH-1:0] pin_arr    [4];
    logic [WIDTH-1:0] stable_arr [4];
    logic [3:0]       set_chg;
    logic [3:0]       chg_next;

    assign pin_arr[0] = pin1;
    assign pin_arr[1] = pin2;
    assign pin_arr[2] = pin3;
    assign pin_arr[3] = pin4;

    for (genvar p = 0; p < 4; p++) begin : g_port
        logic [WIDTH-1:0] sync_q [SYNC_STAGES];
        logic [WIDTH-1:0] cand;
        logic [WIDTH-1:0] stable;
        logic [CW-1:0]    cnt;
        logic [WIDTH-1:0] samp;

        assign samp = sync_q[SYNC_STAGES-1];

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                for (int s = 0; s < SYNC_STAGES; s++) begin
                    sync_q[s] <= '0;
                end
                cand   <= '0;
                cnt    <= '0;
                stable <= '0;
            end else begin
                sync_q[0] <= pin_arr[p];
                for (int s = 1; s < SYNC_STAGES; s++) begin
                    sync_q[s] <= sync_q[s-1];
                end
                // Any change restarts the run; acceptance needs the count to saturate first.
                if (samp != cand) begin
                    cand <= samp;
                    cnt  <= '0;
                end else if (cnt == CNT_MAX && cand != stable) begin
                    stable <= cand;
                end else if (cnt < CNT_MAX) begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        assign set_chg[p]    = (samp == cand) && (cnt == CNT_MAX) && (cand != stable);
        assign stable_arr[p] = stable;
    end

    assign i1 = stable_arr[0];
    assign i2 = stable_arr[1];
    assign i3 = stable_arr[2];
    assign i4 = stable_arr[3];

    // A set on the same edge as the read acknowledge wins so no update is lost.
    always_comb begin
        chg_next = chg;
        for (int n = 0; n < 4; n++) begin
            if (set_chg[n]) begin
                chg_next[n] = 1'b1;
            end else if (rd_ack && s_port == 2'(n)) begin
                chg_next[n] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chg <= '0;
        end else begin
            chg <= chg_next;
        end
    end

`ifdef PORT_IRQ_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq <= 1'b0;
        end else begin
            irq <= |(chg_next & irq_mask);
        end
    end
`else
    logic unused_irq_mask;
    assign unused_irq_mask = ^irq_mask;
    assign irq             = 1'b0;
`endif

endmodule

// File: tb/tb_port_in_sync.sv
// Self-checking bench for port_in_sync: directed scenarios plus randomized pin activity
// compared against a delay-line / run-length reference model.
module tb_port_in_sync;

    localparam int W    = 8;
    localparam int SYNC = 2;
    localparam int DEB  = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] pins [4];
    logic [1:0]   s_port;
    logic         rd_ack;
    logic [3:0]   irq_mask;
    logic [W-1:0] i1, i2, i3, i4;
    logic [3:0]   chg;
    logic         irq;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic [W-1:0] m_hist   [4][$];
    logic [W-1:0] m_win    [4][$];
    logic [W-1:0] m_stable [4];
    logic [3:0]   m_chg;
    logic         m_irq;

    port_in_sync #(.WIDTH(W), .SYNC_STAGES(SYNC), .DEB_CYCLES(DEB)) dut (
        .clk(clk), .reset(reset),
        .pin1(pins[0]), .pin2(pins[1]), .pin3(pins[2]), .pin4(pins[3]),
        .s_port(s_port), .rd_ack(rd_ack), .irq_mask(irq_mask),
        .i1(i1), .i2(i2), .i3(i3), .i4(i4), .chg(chg), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < 4; p++) begin
            m_hist[p].delete();
            m_win[p].delete();
            repeat (SYNC) m_hist[p].push_back('0);
            repeat (DEB + 1) m_win[p].push_back('0);
            m_stable[p] = '0;
        end
        m_chg = '0;
        m_irq = 1'b0;
    endtask

    // A value is accepted once DEB+1 consecutive synchronised samples agree on it.
    task automatic model_step();
        logic [3:0]   set_v;
        logic [W-1:0] samp;
        bit           all_eq;
        set_v = '0;
        for (int p = 0; p < 4; p++) begin
            samp = m_hist[p].pop_front();
            m_hist[p].push_back(pins[p]);
            void'(m_win[p].pop_front());
            m_win[p].push_back(samp);
            all_eq = 1;
            foreach (m_win[p][k]) if (m_win[p][k] != samp) all_eq = 0;
            if (all_eq && samp != m_stable[p]) begin
                m_stable[p] = samp;
                set_v[p]    = 1'b1;
            end
        end
        if (rd_ack && !set_v[s_port]) m_chg[s_port] = 1'b0;
        m_chg = m_chg | set_v;
`ifdef PORT_IRQ_EN
        m_irq = |(m_chg & irq_mask);
`endif
    endtask

    task automatic compare_all();
        check("i1", 32'(i1), 32'(m_stable[0]));
        check("i2", 32'(i2), 32'(m_stable[1]));
        check("i3", 32'(i3), 32'(m_stable[2]));
        check("i4", 32'(i4), 32'(m_stable[3]));
        check("chg", 32'(chg), 32'(m_chg));
        check("irq", 32'(irq), 32'(m_irq));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic ack(input int port);
        s_port = 2'(port);
        rd_ack = 1'b1;
        cycle();
        rd_ack = 1'b0;
    endtask

    initial begin
        reset    = 1'b0;
        s_port   = '0;
        rd_ack   = 1'b0;
        irq_mask = '0;
        for (int p = 0; p < 4; p++) pins[p] = 8'hFF;
        model_reset();

        // reset holds everything at zero despite active pins
        #32;
        check("rst_i1", 32'(i1), 32'h0);
        check("rst_i4", 32'(i4), 32'h0);
        check("rst_chg", 32'(chg), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        reset = 1'b1;

        repeat (6) cycle();
        check("t1_early_i1", 32'(i1), 32'h0);
        cycle();
        check("t1_i1", 32'(i1), 32'hFF);
        check("t1_i3", 32'(i3), 32'hFF);
        check("t1_chg", 32'(chg), 32'hF);

        // latency and read-clear
        for (int p = 0; p < 4; p++) pins[p] = 8'h00;
        repeat (10) cycle();
        for (int p = 0; p < 4; p++) ack(p);
        check("t2_clr_all", 32'(chg), 32'h0);
        pins[1] = 8'h5A;
        repeat (6) cycle();
        check("t2_early_i2", 32'(i2), 32'h0);
        cycle();
        check("t2_i2", 32'(i2), 32'h5A);
        check("t2_chg", 32'(chg), 32'h2);
        ack(0);
        check("t2_other_port", 32'(chg), 32'h2);
        ack(1);
        check("t2_cleared", 32'(chg), 32'h0);

        // glitches of 3 and 4 cycles rejected, 5 accepted
        for (int w = 3; w <= 4; w++) begin
            pins[2] = 8'h33;
            repeat (w) cycle();
            pins[2] = 8'h00;
            repeat (10) cycle();
            check("t3_glitch_i3", 32'(i3), 32'h0);
            check("t3_glitch_chg", 32'(chg[2]), 32'h0);
        end
        pins[2] = 8'h33;
        repeat (5) cycle();
        pins[2] = 8'h00;
        repeat (2) cycle();
        check("t3_accept_i3", 32'(i3), 32'h33);
        check("t3_accept_chg", 32'(chg[2]), 32'h1);
        repeat (10) cycle();
        check("t3_return_i3", 32'(i3), 32'h0);
        ack(2);

        // set and clear on the same edge
        pins[3] = 8'h77;
        repeat (6) cycle();
        ack(3);
        check("t4_collide_chg", 32'(chg[3]), 32'h1);
        check("t4_i4", 32'(i4), 32'h77);
        ack(3);
        check("t4_clear_chg", 32'(chg[3]), 32'h0);

        // asynchronous reset in the middle of a debounce
        pins[0] = 8'hC3;
        repeat (10) cycle();
        check("t5_pre_i1", 32'(i1), 32'hC3);
        pins[0] = 8'h3C;
        repeat (3) cycle();
        #1;
        reset = 1'b0;
        model_reset();
        #1;
        check("t5_async_i1", 32'(i1), 32'h0);
        check("t5_async_i4", 32'(i4), 32'h0);
        check("t5_async_chg", 32'(chg), 32'h0);
        #1;
        reset = 1'b1;
        repeat (6) cycle();
        check("t5_early_i1", 32'(i1), 32'h0);
        cycle();
        check("t5_i1", 32'(i1), 32'h3C);
        check("t5_i4", 32'(i4), 32'h77);
        for (int p = 0; p < 4; p++) ack(p);

`ifdef PORT_IRQ_EN
        irq_mask = 4'b0100;
        pins[0]  = 8'h11;
        repeat (8) cycle();
        check("t6_masked_irq", 32'(irq), 32'h0);
        pins[2] = 8'h44;
        repeat (7) cycle();
        check("t6_irq_set", 32'(irq), 32'h1);
        ack(2);
        check("t6_irq_clr", 32'(irq), 32'h0);
`endif

        // randomized pin activity with random reads and masks
        for (int c = 0; c < 600; c++) begin
            for (int p = 0; p < 4; p++) begin
                if ($urandom_range(0, 7) == 0) begin
                    pins[p] = ($urandom_range(0, 3) == 0) ? m_stable[p] : 8'($urandom);
                end
            end
            rd_ack   = ($urandom_range(0, 3) == 0);
            s_port   = 2'($urandom_range(0, 3));
            irq_mask = 4'($urandom_range(0, 15));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
